pipeline_controller: RTL

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It takes hazard information from the IF/ID and ID/EX registers, resolved branches from EX, and memory wait from MEM. It produces the stall and flush controls for the PC, IF/ID, ID/EX (id_stall_i/id_flush_i of the decode stage) and EX/MEM registers. It also runs the trap drain/halt sequence for ECALL/EBREAK and keeps a stall-cycle performance counter.

---
 rtl/pipeline_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stall/flush steering,
// trap drain-and-halt sequencing, and a saturating stall-cycle counter.
module pipeline_controller #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_use_mem_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_trap_i,
  input  logic             mem_busy_i,
  input  logic             resume_i,
  input  logic             clear_cnt_i,
  output logic             pc_stall_o,
  output logic             if_stall_o,
  output logic             if_flush_o,
  output logic             id_stall_o,
  output logic             id_flush_o,
  output logic             ex_stall_o,
  output logic             halted_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HALTED  = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic pc_stall, if_stall, if_flush, id_stall, id_flush, ex_stall;

  // No rs-valid qualification: a false stall on formats without rs2 is harmless.
  assign load_use = ex_use_mem_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    cnt_d    = cnt_q;
    pc_stall = 1'b0;
    if_stall = 1'b0;
    if_flush = 1'b0;
    id_stall = 1'b0;
    id_flush = 1'b0;
    ex_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_busy_i) begin
          pc_stall = 1'b1;
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_stall = 1'b1;
        end else if (ex_trap_i) begin
          pc_stall = 1'b1;
          if_flush = 1'b1;
          id_flush = 1'b1;
          state_d  = DRAIN;
          drain_d  = DCW'(DRAIN_CYCLES - 1);
        end else if (ex_branch_taken_i) begin
          if_flush = 1'b1;
          id_flush = 1'b1;
        end else if (load_use) begin
          pc_stall = 1'b1;
          if_stall = 1'b1;
          id_flush = 1'b1;
        end
        // Load-use only counts when it actually won arbitration.
        if (clear_cnt_i)
          cnt_d = '0;
        else if ((mem_busy_i || (load_use && !ex_trap_i && !ex_branch_taken_i)) &&
                 (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + CNT_W'(1);
      end
      DRAIN: begin
        pc_stall = 1'b1;
        if_flush = 1'b1;
        id_flush = 1'b1;
        if (mem_busy_i) begin
          id_stall = 1'b1;
          ex_stall = 1'b1;
        end else if (drain_q == '0) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      HALTED: begin
        pc_stall = 1'b1;
        if_flush = 1'b1;
        id_flush = 1'b1;
        if (resume_i) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        drain_d = '0;
      end
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Controls are combinational from live inputs, so gate them off during reset.
  assign pc_stall_o    = reset_n & pc_stall;
  assign if_stall_o    = reset_n & if_stall;
  assign if_flush_o    = reset_n & if_flush;
  assign id_stall_o    = reset_n & id_stall;
  assign id_flush_o    = reset_n & id_flush;
  assign ex_stall_o    = reset_n & ex_stall;
  assign halted_o      = halted_q;
  assign state_o       = state_q;
  assign stall_count_o = cnt_q;

endmodule
